control_unit_multicycle_mips: RTL and testbench
===============================================

Name: control_unit_multicycle_mips

Overview:
- Multi-cycle successor to the single-cycle main/ALU control pair. One FSM sequences fetch, decode, execute, memory and writeback over several clocks. The ALU control decode is folded in, so a single block drives a shared-ALU, shared-memory MIPS data tract.
- Adds a memory ready handshake with timeout, illegal-opcode/funct detection and a configurable halt policy.

Parameters:
- MEM_HANDSHAKE, 1: 1 = memory states wait for i_mem_ready; 0 = memory always completes in one cycle and i_mem_ready is ignored.
- MEM_TIMEOUT, 15: maximum wait cycles per memory state before a fault. Counter width is clog2(MEM_TIMEOUT+1).
- HALT_ON_ILLEGAL, 1: 1 = illegal instruction enters HALT; 0 = pulse o_illegal and return to FETCH.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_op_code  in  6  instruction[31:26] from the instruction register.
- i_funct  in  6  instruction[5:0] from the instruction register.
- i_mem_ready  in  1  memory access completes this cycle.
- o_iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- o_mem_read  out  1  memory read request.
- o_mem_write  out  1  memory write request.
- o_ir_write  out  1  load the instruction register.
- o_pc_write  out  1  unconditional PC load.
- o_pc_write_cond  out  1  PC load qualified by the ALU zero flag.
- o_branch_ne  out  1  invert the zero qualification (bne).
- o_pc_src  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- o_alu_src_a  out  1  ALU operand A: 0 = PC, 1 = rs.
- o_alu_src_b  out  2  ALU operand B: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- o_alu_control  out  6  {op_type_1[1:0], op_type_2[1:0], op_type_3, is_signed}.
- o_reg_write  out  1  register file write enable.
- o_reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- o_mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- o_instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- o_illegal  out  1  illegal opcode or funct detected.
- o_mem_fault  out  1  memory timeout; sticky until reset.
- o_state  out  4  current state encoding, for debug.

Behaviour:
- Output timing: all outputs are Moore-decoded from the registered state. Exceptions: ir_write and pc_write in FETCH, and the done pulse in memory states, are gated by the ready condition (ready = i_mem_ready, or 1 when MEM_HANDSHAKE=0).
- Reset: state = FETCH, wait counter = 0, o_mem_fault = 0, o_illegal = 0, latched op/funct = 0.
  - Reset outputs are those of FETCH with the ready input low: o_mem_read = 1, o_iord = 0, o_alu_src_a = 0, o_alu_src_b = 01, o_alu_control = add; everything else 0.
  - Reset wins over any concurrent event, including mid-access and in HALT.
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9, IMM_EXEC 10, IMM_WB 11, HALT 15.
- FETCH:
  - Outputs: mem_read, PC+4 on the ALU.
  - On ready: ir_write, pc_write with pc_src = 00, then go to DECODE. Otherwise stay.
- DECODE:
  - Compute PC + (imm << 2) into ALUOut (src_a = 0, src_b = 11, add).
  - Latch i_op_code and i_funct, then dispatch:
    - 0x00 -> EXECUTE; the funct is checked first and an unknown funct goes to the illegal path.
    - 0x23 and 0x2B -> MEM_ADDR.
    - 0x04 and 0x05 -> BRANCH.
    - 0x02 -> JUMP.
    - 0x08 (signed) and 0x09 (unsigned) -> IMM_EXEC.
    - Anything else goes to the illegal path.
- MEM_ADDR: src_a = 1, src_b = 10, add. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read, iord = 1. On ready go to MEM_WB; otherwise stay.
- MEM_WB: reg_write, mem_to_reg = 1, reg_dst = 0, instr_done. Then FETCH.
- MEM_WRITE: mem_write, iord = 1. On ready assert instr_done and go to FETCH.
- EXECUTE: src_a = 1, src_b = 00, ALU control from the latched funct:
  - 0x00 sll = 000000; 0x02 srl = 000010; 0x03 sra = 001010.
  - 0x20 add = 100000; 0x22 sub = 100100.
  - 0x24 and = 110000; 0x25 or = 110100; 0x26 xor = 111100; 0x27 nor = 111000.
  - is_signed = 1 for add and sub.
  - Then go to ALU_WB.
- ALU_WB: reg_write, reg_dst = 1, mem_to_reg = 0, instr_done. Then FETCH.
- BRANCH:
  - src_a = 1, src_b = 00, sub (100100), pc_write_cond, pc_src = 01, branch_ne = (op == 0x05).
  - Assert instr_done and go to FETCH.
- JUMP: pc_write, pc_src = 10, instr_done. Then FETCH.
- IMM_EXEC: src_a = 1, src_b = 10, add; is_signed = 1 for 0x08, 0 for 0x09. Then IMM_WB.
- IMM_WB: reg_write, reg_dst = 0, mem_to_reg = 0, instr_done. Then FETCH.
- Illegal path:
  - o_illegal is asserted from the cycle after DECODE.
  - HALT_ON_ILLEGAL = 1: go to HALT. o_illegal is held high in HALT and all enables are 0 until reset.
  - HALT_ON_ILLEGAL = 0: o_illegal is a one-cycle pulse in place of the EXECUTE cycle, then FETCH. No register or memory writes occur.
- Wait counter:
  - Clears on entry to each memory state (FETCH, MEM_READ, MEM_WRITE) and increments each not-ready cycle.
  - When it reaches MEM_TIMEOUT with ready still low: set o_mem_fault and go to HALT; the outstanding request is dropped.
  - Ready arriving in the same cycle the count reaches MEM_TIMEOUT counts as success.
- Latency with zero wait: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3 cycles. Each wait cycle adds 1.

Test Plan:
- Reset, then ready tied to 1, lw (op 0x23) -> states 0,1,2,3,4; mem_to_reg = 1 and reg_write = 1 in state 4; instr_done pulses once at cycle 5.
- R-type op 0x00 with funct 0x03 -> EXECUTE shows o_alu_control = 001010; ALU_WB has reg_dst = 1; then funct 0x26 gives 111100.
- sw, with ready held low for 3 cycles in MEM_WRITE -> mem_write held 4 cycles; instr_done pulses on the ready cycle; total 7 cycles.
- bne (0x05) -> BRANCH has pc_write_cond = 1, branch_ne = 1, pc_src = 01, alu_control = 100100; beq has branch_ne = 0.
- With MEM_TIMEOUT = 15 and ready stuck low in FETCH -> o_mem_fault rises after 15 wait cycles; o_state = 15; all enables 0; i_reset returns to FETCH with the fault cleared.
- Opcode 0x3F with HALT_ON_ILLEGAL = 1 -> HALT, o_illegal held high. With HALT_ON_ILLEGAL = 0 -> a one-cycle o_illegal pulse, then FETCH, with no reg_write or mem_write asserted.

Source files
------------

// File: rtl/control_unit_multicycle_mips.sv
// Multi-cycle MIPS control unit: one FSM sequences fetch/decode/execute/memory/writeback
// and drives the shared ALU, memory and register file, including the folded-in ALU control decode.
module control_unit_multicycle_mips #(
    parameter bit          MEM_HANDSHAKE   = 1'b1,
    parameter int unsigned MEM_TIMEOUT     = 15,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_op_code,
    input  logic [5:0] i_funct,
    input  logic       i_mem_ready,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_branch_ne,
    output logic [1:0] o_pc_src,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [5:0] o_alu_control,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_instr_done,
    output logic       o_illegal,
    output logic       o_mem_fault,
    output logic [3:0] o_state
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU control words {op_type_1, op_type_2, op_type_3, is_signed}
    localparam logic [5:0] ALU_SLL = 6'b000000;
    localparam logic [5:0] ALU_SRL = 6'b000010;
    localparam logic [5:0] ALU_SRA = 6'b001010;
    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100100;
    localparam logic [5:0] ALU_AND = 6'b110000;
    localparam logic [5:0] ALU_OR  = 6'b110100;
    localparam logic [5:0] ALU_XOR = 6'b111100;
    localparam logic [5:0] ALU_NOR = 6'b111000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_IMM_EXEC  = 4'd10,
        S_IMM_WB    = 4'd11,
        S_HALT      = 4'd15
    } state_t;

    state_t           state;
    state_t           decode_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [5:0]       op_q;
    logic [5:0]       funct_q;
    logic             illegal_q;
    logic             fault_q;
    logic             ready;
    logic             mem_state;
    logic             timed_out;
    logic             decode_illegal;

    function automatic logic funct_known(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h20, 6'h22,
            6'h24, 6'h25, 6'h26, 6'h27: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic [5:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'h00:   return ALU_SLL;
            6'h02:   return ALU_SRL;
            6'h03:   return ALU_SRA;
            6'h20:   return ALU_ADD | 6'b000001;
            6'h22:   return ALU_SUB | 6'b000001;
            6'h24:   return ALU_AND;
            6'h25:   return ALU_OR;
            6'h26:   return ALU_XOR;
            6'h27:   return ALU_NOR;
            default: return 6'b000000;
        endcase
    endfunction

    assign ready     = MEM_HANDSHAKE ? i_mem_ready : 1'b1;
    assign mem_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    // Ready in the cycle the count sits at the limit still succeeds
    assign timed_out = mem_state && !ready && (wait_cnt == CNT_W'(MEM_TIMEOUT));

    // Opcode/funct dispatch out of DECODE, using the live instruction register fields
    always_comb begin
        decode_illegal = 1'b0;
        decode_next    = S_HALT;
        case (i_op_code)
            OP_RTYPE: begin
                if (funct_known(i_funct)) decode_next = S_EXECUTE;
                else                      decode_illegal = 1'b1;
            end
            OP_LW, OP_SW:      decode_next = S_MEM_ADDR;
            OP_BEQ, OP_BNE:    decode_next = S_BRANCH;
            OP_J:              decode_next = S_JUMP;
            OP_ADDI, OP_ADDIU: decode_next = S_IMM_EXEC;
            default:           decode_illegal = 1'b1;
        endcase
        if (decode_illegal) decode_next = HALT_ON_ILLEGAL ? S_HALT : S_EXECUTE;
    end

    // Sequencer: state, latched instruction fields, wait counter and sticky flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            op_q      <= '0;
            funct_q   <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            if (state == S_DECODE)    illegal_q <= decode_illegal;
            else if (state != S_HALT) illegal_q <= 1'b0;

            if (timed_out) begin
                state    <= S_HALT;
                fault_q  <= 1'b1;
                wait_cnt <= '0;
            end else begin
                // Every memory state exits on ready, so clearing here also clears on entry
                if (mem_state && !ready) wait_cnt <= wait_cnt + 1'b1;
                else                     wait_cnt <= '0;

                case (state)
                    S_FETCH:     if (ready) state <= S_DECODE;
                    S_DECODE: begin
                        op_q    <= i_op_code;
                        funct_q <= i_funct;
                        state   <= decode_next;
                    end
                    S_MEM_ADDR:  state <= (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                    S_MEM_READ:  if (ready) state <= S_MEM_WB;
                    S_MEM_WB:    state <= S_FETCH;
                    S_MEM_WRITE: if (ready) state <= S_FETCH;
                    S_EXECUTE:   state <= illegal_q ? S_FETCH : S_ALU_WB;
                    S_ALU_WB:    state <= S_FETCH;
                    S_BRANCH:    state <= S_FETCH;
                    S_JUMP:      state <= S_FETCH;
                    S_IMM_EXEC:  state <= S_IMM_WB;
                    S_IMM_WB:    state <= S_FETCH;
                    S_HALT:      state <= S_HALT;
                    default:     state <= S_HALT;
                endcase
            end
        end
    end

    assign o_state     = 4'(state);
    assign o_illegal   = illegal_q;
    assign o_mem_fault = fault_q;

    // Moore output decode; only FETCH and MEM_WRITE look at ready
    always_comb begin
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_branch_ne     = 1'b0;
        o_pc_src        = 2'b00;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = 2'b00;
        o_alu_control   = 6'b000000;
        o_reg_write     = 1'b0;
        o_reg_dst       = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_instr_done    = 1'b0;
        case (state)
            S_FETCH: begin
                o_mem_read    = 1'b1;
                o_alu_src_b   = 2'b01;
                o_alu_control = ALU_ADD;
                o_ir_write    = ready;
                o_pc_write    = ready;
            end
            S_DECODE: begin
                o_alu_src_b   = 2'b11;
                o_alu_control = ALU_ADD;
            end
            S_MEM_ADDR: begin
                o_alu_src_a   = 1'b1;
                o_alu_src_b   = 2'b10;
                o_alu_control = ALU_ADD;
            end
            S_MEM_READ: begin
                o_mem_read = 1'b1;
                o_iord     = 1'b1;
            end
            S_MEM_WB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
                o_instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                o_mem_write  = 1'b1;
                o_iord       = 1'b1;
                o_instr_done = ready;
            end
            S_EXECUTE: begin
                if (!illegal_q) begin
                    o_alu_src_a   = 1'b1;
                    o_alu_control = rtype_alu(funct_q);
                end
            end
            S_ALU_WB: begin
                o_reg_write  = 1'b1;
                o_reg_dst    = 1'b1;
                o_instr_done = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_control   = ALU_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_src        = 2'b01;
                o_branch_ne     = (op_q == OP_BNE);
                o_instr_done    = 1'b1;
            end
            S_JUMP: begin
                o_pc_write   = 1'b1;
                o_pc_src     = 2'b10;
                o_instr_done = 1'b1;
            end
            S_IMM_EXEC: begin
                o_alu_src_a   = 1'b1;
                o_alu_src_b   = 2'b10;
                o_alu_control = ALU_ADD | {5'b00000, (op_q == OP_ADDI)};
            end
            S_IMM_WB: begin
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit_multicycle_mips.sv
// Bench for control_unit_multicycle_mips: per-instruction expected cycle traces built from the
// instruction class and memory wait counts, checked on a halting and a non-halting instance.
module tb_control_unit_multicycle_mips;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100100;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       src_a;
        logic [1:0] src_b;
        logic [5:0] alu;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       done;
        logic       illegal;
        logic       fault;
        logic [3:0] state;
    } ctl_t;

    typedef struct {
        ctl_t  ea;
        ctl_t  eb;
        bit    rdy;
        bit    scr;
        string tag;
    } step_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op_code;
    logic [5:0] funct;
    logic       mem_ready;

    logic       iord_a, mem_read_a, mem_write_a, ir_write_a, pc_write_a, pc_write_cond_a, branch_ne_a;
    logic [1:0] pc_src_a, alu_src_b_a;
    logic       alu_src_a_a, reg_write_a, reg_dst_a, mem_to_reg_a, done_a, illegal_a, fault_a;
    logic [5:0] alu_a;
    logic [3:0] state_a;
    logic       iord_b, mem_read_b, mem_write_b, ir_write_b, pc_write_b, pc_write_cond_b, branch_ne_b;
    logic [1:0] pc_src_b, alu_src_b_b;
    logic       alu_src_a_b, reg_write_b, reg_dst_b, mem_to_reg_b, done_b, illegal_b, fault_b;
    logic [5:0] alu_b;
    logic [3:0] state_b;

    ctl_t obs_a, obs_b;
    assign obs_a = {iord_a, mem_read_a, mem_write_a, ir_write_a, pc_write_a, pc_write_cond_a,
                    branch_ne_a, pc_src_a, alu_src_a_a, alu_src_b_a, alu_a, reg_write_a,
                    reg_dst_a, mem_to_reg_a, done_a, illegal_a, fault_a, state_a};
    assign obs_b = {iord_b, mem_read_b, mem_write_b, ir_write_b, pc_write_b, pc_write_cond_b,
                    branch_ne_b, pc_src_b, alu_src_a_b, alu_src_b_b, alu_b, reg_write_b,
                    reg_dst_b, mem_to_reg_b, done_b, illegal_b, fault_b, state_b};

    always #5 clk = ~clk;

    control_unit_multicycle_mips #(.MEM_HANDSHAKE(1'b1), .MEM_TIMEOUT(15), .HALT_ON_ILLEGAL(1'b1)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_op_code(op_code), .i_funct(funct), .i_mem_ready(mem_ready),
        .o_iord(iord_a), .o_mem_read(mem_read_a), .o_mem_write(mem_write_a), .o_ir_write(ir_write_a),
        .o_pc_write(pc_write_a), .o_pc_write_cond(pc_write_cond_a), .o_branch_ne(branch_ne_a),
        .o_pc_src(pc_src_a), .o_alu_src_a(alu_src_a_a), .o_alu_src_b(alu_src_b_a),
        .o_alu_control(alu_a), .o_reg_write(reg_write_a), .o_reg_dst(reg_dst_a),
        .o_mem_to_reg(mem_to_reg_a), .o_instr_done(done_a), .o_illegal(illegal_a),
        .o_mem_fault(fault_a), .o_state(state_a)
    );

    control_unit_multicycle_mips #(.MEM_HANDSHAKE(1'b1), .MEM_TIMEOUT(15), .HALT_ON_ILLEGAL(1'b0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_op_code(op_code), .i_funct(funct), .i_mem_ready(mem_ready),
        .o_iord(iord_b), .o_mem_read(mem_read_b), .o_mem_write(mem_write_b), .o_ir_write(ir_write_b),
        .o_pc_write(pc_write_b), .o_pc_write_cond(pc_write_cond_b), .o_branch_ne(branch_ne_b),
        .o_pc_src(pc_src_b), .o_alu_src_a(alu_src_a_b), .o_alu_src_b(alu_src_b_b),
        .o_alu_control(alu_b), .o_reg_write(reg_write_b), .o_reg_dst(reg_dst_b),
        .o_mem_to_reg(mem_to_reg_b), .o_instr_done(done_b), .o_illegal(illegal_b),
        .o_mem_fault(fault_b), .o_state(state_b)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    step_t trace[$];
    bit    need_reset;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom % 2);
    endfunction

    function automatic ctl_t st_only(input logic [3:0] s);
        ctl_t c;
        c       = '0;
        c.state = s;
        return c;
    endfunction

    function automatic ctl_t fetch_c(input bit rdy);
        ctl_t c;
        c          = st_only(4'd0);
        c.mem_read = 1'b1;
        c.src_b    = 2'b01;
        c.alu      = ADD;
        c.ir_write = rdy;
        c.pc_write = rdy;
        return c;
    endfunction

    // R-type funct table: returns legality and the ALU control word
    function automatic bit rtype_code(input logic [5:0] f, output logic [5:0] code);
        code = 6'b000000;
        case (f)
            6'h00: code = 6'b000000;
            6'h02: code = 6'b000010;
            6'h03: code = 6'b001010;
            6'h20: code = 6'b100001;
            6'h22: code = 6'b100101;
            6'h24: code = 6'b110000;
            6'h25: code = 6'b110100;
            6'h26: code = 6'b111100;
            6'h27: code = 6'b111000;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic push(input ctl_t ea, input ctl_t eb, input bit rdy, input bit scr, input string tag);
        step_t s;
        s.ea = ea; s.eb = eb; s.rdy = rdy; s.scr = scr; s.tag = tag;
        trace.push_back(s);
    endtask

    // Memory phase with w not-ready cycles; 16 or more is a timeout into a faulted halt
    task automatic add_mem(input int kind, input int w, output bit ok);
        ctl_t c;
        int   n;
        n = (w > 15) ? 16 : w;
        for (int i = 0; i <= n; i++) begin
            bit r;
            r = (i == n) && (w <= 15);
            if (i == n && !r) break;
            case (kind)
                0: c = fetch_c(r);
                1: begin c = st_only(4'd3); c.mem_read = 1'b1; c.iord = 1'b1; end
                default: begin c = st_only(4'd5); c.mem_write = 1'b1; c.iord = 1'b1; c.done = r; end
            endcase
            push(c, c, r, kind != 0, (kind == 0) ? "fetch" : (kind == 1) ? "mem_read" : "mem_write");
        end
        ok = (w <= 15);
        if (!ok) begin
            c       = st_only(4'd15);
            c.fault = 1'b1;
            push(c, c, rb(), 1'b1, "fault_halt");
            push(c, c, rb(), 1'b1, "fault_hold");
            need_reset = 1'b1;
        end
    endtask

    task automatic add_illegal();
        ctl_t a, b;
        a = st_only(4'd15); a.illegal = 1'b1;
        b = st_only(4'd6);  b.illegal = 1'b1;
        push(a, b, rb(), 1'b1, "illegal");
        b = fetch_c(1'b0);
        push(a, b, 1'b0, 1'b1, "after_illegal");
        need_reset = 1'b1;
    endtask

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm);
        ctl_t       c;
        bit         ok;
        logic [5:0] code;
        trace.delete();
        need_reset = 1'b0;
        add_mem(0, wf, ok);
        if (!ok) return;
        c = st_only(4'd1); c.src_b = 2'b11; c.alu = ADD;
        push(c, c, rb(), 1'b0, "decode");
        case (op)
            6'h23, 6'h2B: begin
                c = st_only(4'd2); c.src_a = 1'b1; c.src_b = 2'b10; c.alu = ADD;
                push(c, c, rb(), 1'b1, "mem_addr");
                add_mem((op == 6'h23) ? 1 : 2, wm, ok);
                if (ok && op == 6'h23) begin
                    c = st_only(4'd4); c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1;
                    push(c, c, rb(), 1'b1, "mem_wb");
                end
            end
            6'h00: begin
                if (rtype_code(fn, code)) begin
                    c = st_only(4'd6); c.src_a = 1'b1; c.alu = code;
                    push(c, c, rb(), 1'b1, "execute");
                    c = st_only(4'd7); c.reg_write = 1'b1; c.reg_dst = 1'b1; c.done = 1'b1;
                    push(c, c, rb(), 1'b1, "alu_wb");
                end else begin
                    add_illegal();
                end
            end
            6'h04, 6'h05: begin
                c = st_only(4'd8); c.src_a = 1'b1; c.alu = SUB; c.pc_write_cond = 1'b1;
                c.pc_src = 2'b01; c.branch_ne = (op == 6'h05); c.done = 1'b1;
                push(c, c, rb(), 1'b1, "branch");
            end
            6'h02: begin
                c = st_only(4'd9); c.pc_write = 1'b1; c.pc_src = 2'b10; c.done = 1'b1;
                push(c, c, rb(), 1'b1, "jump");
            end
            6'h08, 6'h09: begin
                c = st_only(4'd10); c.src_a = 1'b1; c.src_b = 2'b10; c.alu = ADD | {5'b0, op == 6'h08};
                push(c, c, rb(), 1'b1, "imm_exec");
                c = st_only(4'd11); c.reg_write = 1'b1; c.done = 1'b1;
                push(c, c, rb(), 1'b1, "imm_wb");
            end
            default: add_illegal();
        endcase
    endtask

    task automatic run(input int abort_at);
        for (int i = 0; i < trace.size(); i++) begin
            if (abort_at >= 0 && i == abort_at) break;
            @(negedge clk);
            rst       = 1'b0;
            mem_ready = trace[i].rdy;
            if (trace[i].scr) begin
                op_code = 6'($urandom);
                funct   = 6'($urandom);
            end
            #1;
            check($sformatf("%s_a", trace[i].tag), 32'(obs_a), 32'(trace[i].ea));
            check($sformatf("%s_b", trace[i].tag), 32'(obs_b), 32'(trace[i].eb));
        end
    endtask

    // Reset is applied with a random ready and checked while still asserted
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = rb();
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("reset_a", 32'(obs_a), 32'(fetch_c(1'b0)));
        check("reset_b", 32'(obs_b), 32'(fetch_c(1'b0)));
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm,
                            input int abort_at);
        op_code = op;
        funct   = fn;
        build(op, fn, wf, wm);
        run(abort_at);
        if (need_reset || abort_at >= 0) do_reset();
    endtask

    function automatic int rand_wait();
        int r;
        r = int'($urandom_range(0, 31));
        if (r < 26) return r % 4;
        if (r < 30) return 15;
        return 16;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] ops[9];
        logic [5:0] bad_ops[4];
        logic [5:0] rfun[9];
        ops     = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h05, 6'h02, 6'h08, 6'h09};
        bad_ops = '{6'h3F, 6'h01, 6'h10, 6'h22};
        rfun    = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
        rst       = 1'b1;
        op_code   = 6'h00;
        funct     = 6'h00;
        mem_ready = 1'b0;
        do_reset();

        do_instr(6'h23, 6'h11, 0, 0, -1);
        do_instr(6'h00, 6'h03, 0, 0, -1);
        do_instr(6'h00, 6'h26, 0, 0, -1);
        do_instr(6'h2B, 6'h00, 0, 3, -1);
        do_instr(6'h05, 6'h00, 0, 0, -1);
        do_instr(6'h04, 6'h00, 0, 0, -1);
        do_instr(6'h02, 6'h00, 1, 0, -1);
        do_instr(6'h08, 6'h00, 0, 0, -1);
        do_instr(6'h09, 6'h00, 0, 0, -1);
        do_instr(6'h00, 6'h20, 0, 0, -1);
        do_instr(6'h00, 6'h22, 0, 0, -1);
        do_instr(6'h23, 6'h00, 15, 15, -1);
        do_instr(6'h23, 6'h00, 16, 0, -1);
        do_instr(6'h23, 6'h00, 0, 16, -1);
        do_instr(6'h2B, 6'h00, 2, 16, -1);
        do_instr(6'h3F, 6'h00, 0, 0, -1);
        do_instr(6'h00, 6'h01, 0, 0, -1);
        do_instr(6'h23, 6'h00, 0, 5, 5);

        for (int n = 0; n < 60; n++) begin
            int k;
            k = int'($urandom_range(0, 9));
            if (k == 9) begin
                if (rb()) do_instr(bad_ops[$urandom_range(0, 3)], 6'($urandom), rand_wait(), 0, -1);
                else      do_instr(6'h00, 6'h3A, rand_wait(), 0, -1);
            end else begin
                do_instr(ops[k], rfun[$urandom_range(0, 8)], rand_wait(), rand_wait(), -1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
